dct8_stream: RTL and testbench

DCT8_STREAM -- requirements
Module: dct8_stream

---
 rtl/dct8_stream.sv | 185 ++++++++++++++++++
 tb/tb_dct8_stream.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct8_stream.sv
// Streaming 8-point DCT-II: eight parallel MAC lanes (one per coefficient k),
// one input term per cycle, rounded and saturated into registered outputs.
//
// state | meaning
// IDLE  | waiting for a vector, in_ready=1
// CALC  | accumulating terms n=0..7 into all eight lanes
// OUT   | results held until out_ready; can accept the next vector on the same edge
module dct8_stream #(
    parameter int IN_W        = 8,
    parameter int OUT_W       = 14,
    parameter int LEVEL_SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         x0,
    input  logic [IN_W-1:0]         x1,
    input  logic [IN_W-1:0]         x2,
    input  logic [IN_W-1:0]         x3,
    input  logic [IN_W-1:0]         x4,
    input  logic [IN_W-1:0]         x5,
    input  logic [IN_W-1:0]         x6,
    input  logic [IN_W-1:0]         x7,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] y0,
    output logic signed [OUT_W-1:0] y1,
    output logic signed [OUT_W-1:0] y2,
    output logic signed [OUT_W-1:0] y3,
    output logic signed [OUT_W-1:0] y4,
    output logic signed [OUT_W-1:0] y5,
    output logic signed [OUT_W-1:0] y6,
    output logic signed [OUT_W-1:0] y7
);

    localparam int ACC_W = IN_W + 17;
    localparam int PW    = IN_W + 14;
    localparam int RW    = ACC_W + 1 - 12;
    localparam int SW    = ((RW > OUT_W) ? RW : OUT_W) + 1;

    localparam logic signed [IN_W:0] OFFS = {2'b01, {(IN_W-1){1'b0}}};
    localparam logic signed [SW-1:0] MAXV = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t                  state;
    logic [2:0]              n;
    logic [IN_W-1:0]         xin      [8];
    logic [IN_W-1:0]         xs       [8];
    logic signed [ACC_W-1:0] acc      [8];
    logic signed [OUT_W-1:0] y        [8];
    logic signed [12:0]      c_k      [8];
    logic signed [PW-1:0]    prod     [8];
    logic signed [ACC_W-1:0] acc_next [8];
    logic signed [ACC_W:0]   rsum     [8];
    logic signed [SW-1:0]    r        [8];
    logic signed [OUT_W-1:0] y_next   [8];
    logic [IN_W-1:0]         x_cur;
    logic signed [IN_W:0]    s_cur;

    // Cosine table folded by quadrant of k*(2n+1) (period 32 in units of pi/16).
    function automatic logic signed [12:0] coef(input int k, input int nn);
        int                 m;
        int                 idx;
        logic               neg;
        logic signed [12:0] mag;
        m = (k * (2 * nn + 1)) % 32;
        if (m <= 8) begin
            idx = m;      neg = 1'b0;
        end else if (m <= 16) begin
            idx = 16 - m; neg = 1'b1;
        end else if (m <= 24) begin
            idx = m - 16; neg = 1'b1;
        end else begin
            idx = 32 - m; neg = 1'b0;
        end
        case (idx)
            0:       mag = 13'sd1448;
            1:       mag = 13'sd2009;
            2:       mag = 13'sd1892;
            3:       mag = 13'sd1703;
            4:       mag = 13'sd1448;
            5:       mag = 13'sd1138;
            6:       mag = 13'sd784;
            7:       mag = 13'sd400;
            default: mag = 13'sd0;
        endcase
        return neg ? -mag : mag;
    endfunction

    assign xin[0] = x0;
    assign xin[1] = x1;
    assign xin[2] = x2;
    assign xin[3] = x3;
    assign xin[4] = x4;
    assign xin[5] = x5;
    assign xin[6] = x6;
    assign xin[7] = x7;

    assign x_cur = xs[n];
    assign s_cur = (LEVEL_SHIFT != 0) ? ($signed({1'b0, x_cur}) - OFFS)
                                      : $signed({1'b0, x_cur});

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            c_k[k]      = coef(k, int'(n));
            prod[k]     = PW'(s_cur) * PW'(c_k[k]);
            acc_next[k] = acc[k] + ACC_W'(prod[k]);
            rsum[k]     = {acc_next[k][ACC_W-1], acc_next[k]} + (ACC_W+1)'(2048);
            r[k]        = SW'(rsum[k] >>> 12);
            if (r[k] > MAXV)
                y_next[k] = MAXV[OUT_W-1:0];
            else if (r[k] < MINV)
                y_next[k] = MINV[OUT_W-1:0];
            else
                y_next[k] = r[k][OUT_W-1:0];
        end
    end

    assign in_ready = (state == IDLE) || ((state == OUT) && out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n         <= 3'd0;
            out_valid <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                acc[i] <= '0;
                y[i]   <= '0;
                xs[i]  <= '0;
            end
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 8; i++) begin
                            xs[i]  <= xin[i];
                            acc[i] <= '0;
                        end
                        n     <= 3'd0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    for (int i = 0; i < 8; i++) acc[i] <= acc_next[i];
                    n <= n + 3'd1;
                    if (n == 3'd7) begin
                        for (int i = 0; i < 8; i++) y[i] <= y_next[i];
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            for (int i = 0; i < 8; i++) begin
                                xs[i]  <= xin[i];
                                acc[i] <= '0;
                            end
                            n     <= 3'd0;
                            state <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign y0 = y[0];
    assign y1 = y[1];
    assign y2 = y[2];
    assign y3 = y[3];
    assign y4 = y[4];
    assign y5 = y[5];
    assign y6 = y[6];
    assign y7 = y[7];

endmodule

// File: tb/tb_dct8_stream.sv
// Directed bench for dct8_stream: default, level-shifted and narrow-output
// instances driven in lockstep, checked against hand-computed coefficients.
module tb_dct8_stream;

    typedef logic [7:0] vec_t [8];
    typedef int         res_t [8];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, in_valid, out_ready;
    vec_t x_in;
    logic rdy_d, ov_d, rdy_l, ov_l, rdy_s, ov_s;
    logic signed [13:0] yd [8];
    logic signed [13:0] yl [8];
    logic signed [9:0]  ys [8];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    vec_t V128, V255, VALT, VZERO;
    res_t E128, E255, E255_LS, E255_SAT, E_ALT, EZ;

    dct8_stream #(.IN_W(8), .OUT_W(14), .LEVEL_SHIFT(0)) u_def (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy_d),
        .x0(x_in[0]), .x1(x_in[1]), .x2(x_in[2]), .x3(x_in[3]),
        .x4(x_in[4]), .x5(x_in[5]), .x6(x_in[6]), .x7(x_in[7]),
        .out_valid(ov_d), .out_ready(out_ready),
        .y0(yd[0]), .y1(yd[1]), .y2(yd[2]), .y3(yd[3]),
        .y4(yd[4]), .y5(yd[5]), .y6(yd[6]), .y7(yd[7]));

    dct8_stream #(.IN_W(8), .OUT_W(14), .LEVEL_SHIFT(1)) u_ls (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy_l),
        .x0(x_in[0]), .x1(x_in[1]), .x2(x_in[2]), .x3(x_in[3]),
        .x4(x_in[4]), .x5(x_in[5]), .x6(x_in[6]), .x7(x_in[7]),
        .out_valid(ov_l), .out_ready(out_ready),
        .y0(yl[0]), .y1(yl[1]), .y2(yl[2]), .y3(yl[3]),
        .y4(yl[4]), .y5(yl[5]), .y6(yl[6]), .y7(yl[7]));

    dct8_stream #(.IN_W(8), .OUT_W(10), .LEVEL_SHIFT(0)) u_sat (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy_s),
        .x0(x_in[0]), .x1(x_in[1]), .x2(x_in[2]), .x3(x_in[3]),
        .x4(x_in[4]), .x5(x_in[5]), .x6(x_in[6]), .x7(x_in[7]),
        .out_valid(ov_s), .out_ready(out_ready),
        .y0(ys[0]), .y1(ys[1]), .y2(ys[2]), .y3(ys[3]),
        .y4(ys[4]), .y5(ys[5]), .y6(ys[6]), .y7(ys[7]));

    // Present a vector from IDLE/OUT and count enabled edges until out_valid.
    task automatic send_vec(input vec_t v, output int lat);
        @(negedge clk);
        x_in = v;
        in_valid = 1'b1;
        n_cmp++;
        if (rdy_d !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready: in_ready=%b required 1", rdy_d);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (ov_d !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x_in = V128;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({ov_d, ov_l, ov_s} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_out_valid: got %b%b%b required 000", ov_d, ov_l, ov_s);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (int'(yd[k]) !== 0) begin
                n_bad++;
                $display("FAIL reset_y%0d: got %0d required 0", k, yd[k]);
            end
        end
        n_cmp++;
        if ({rdy_d, rdy_l, rdy_s} !== 3'b111) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b%b%b required 111", rdy_d, rdy_l, rdy_s);
        end
        rst = 1'b0; en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rdy_d !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_in_ready: got %b required 1", rdy_d);
        end
    endtask

    task automatic test_default();
        int lat;
        out_ready = 1'b1;
        send_vec(V128, lat);
        n_cmp++;
        if (lat !== 8) begin
            n_bad++;
            $display("FAIL default_latency: got %0d edges required 8", lat);
        end
        n_cmp++;
        if ({ov_l, ov_s} !== 2'b11) begin
            n_bad++;
            $display("FAIL default_valid_all: got %b%b required 11", ov_l, ov_s);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (int'(yd[k]) !== E128[k]) begin
                n_bad++;
                $display("FAIL default_y%0d: got %0d required %0d", k, yd[k], E128[k]);
            end
            n_cmp++;
            if (int'(yl[k]) !== 0) begin
                n_bad++;
                $display("FAIL shift128_y%0d: got %0d required 0", k, yl[k]);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (ov_d !== 1'b0 || rdy_d !== 1'b1) begin
            n_bad++;
            $display("FAIL default_retire: out_valid=%b in_ready=%b required 0/1", ov_d, rdy_d);
        end
    endtask

    task automatic test_full_scale();
        int lat;
        send_vec(V255, lat);
        n_cmp++;
        if (lat !== 8) begin
            n_bad++;
            $display("FAIL full_latency: got %0d required 8", lat);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (int'(yd[k]) !== E255[k]) begin
                n_bad++;
                $display("FAIL full_y%0d: got %0d required %0d", k, yd[k], E255[k]);
            end
            n_cmp++;
            if (int'(yl[k]) !== E255_LS[k]) begin
                n_bad++;
                $display("FAIL shift255_y%0d: got %0d required %0d", k, yl[k], E255_LS[k]);
            end
            n_cmp++;
            if (int'(ys[k]) !== E255_SAT[k]) begin
                n_bad++;
                $display("FAIL clamp255_y%0d: got %0d required %0d", k, ys[k], E255_SAT[k]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alternating();
        int lat;
        send_vec(VALT, lat);
        n_cmp++;
        if (lat !== 8) begin
            n_bad++;
            $display("FAIL alt_latency: got %0d required 8", lat);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (int'(yd[k]) !== E_ALT[k]) begin
                n_bad++;
                $display("FAIL alt_y%0d: got %0d required %0d", k, yd[k], E_ALT[k]);
            end
            n_cmp++;
            if (int'(ys[k]) !== E_ALT[k]) begin
                n_bad++;
                $display("FAIL alt_narrow_y%0d: got %0d required %0d", k, ys[k], E_ALT[k]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        vec_t vq [4];
        res_t eq [4];
        int   acc_c [4];
        int   ia, io, lat;
        bit   took;
        vq[0] = V128; vq[1] = V255; vq[2] = VALT; vq[3] = VZERO;
        eq[0] = E128; eq[1] = E255; eq[2] = E_ALT; eq[3] = EZ;
        for (int i = 0; i < 4; i++) acc_c[i] = 0;
        ia = 0; io = 0; out_ready = 1'b1;
        @(negedge clk);
        x_in = vq[0];
        in_valid = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (ov_d === 1'b1) begin
                if (io < 4) begin
                    for (int k = 0; k < 8; k++) begin
                        n_cmp++;
                        if (int'(yd[k]) !== eq[io][k]) begin
                            n_bad++;
                            $display("FAIL b2b_v%0d_y%0d: got %0d required %0d", io, k, yd[k], eq[io][k]);
                        end
                    end
                    n_cmp++;
                    if (cyc - acc_c[io] !== 8) begin
                        n_bad++;
                        $display("FAIL b2b_latency_v%0d: got %0d required 8", io, cyc - acc_c[io]);
                    end
                end
                io++;
            end
            took = (in_valid === 1'b1) && (rdy_d === 1'b1);
            if (took) begin
                acc_c[ia] = cyc + 1;
                ia++;
            end
            @(posedge clk); #1;
            if (took) begin
                if (ia < 4) x_in = vq[ia];
                else        in_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (io !== 4 || ia !== 4) begin
            n_bad++;
            $display("FAIL b2b_count: results=%0d accepts=%0d required 4/4", io, ia);
        end
        for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (acc_c[i] - acc_c[i-1] !== 9) begin
                n_bad++;
                $display("FAIL b2b_interval%0d: got %0d required 9", i, acc_c[i] - acc_c[i-1]);
            end
        end

        // Hold the result with out_ready=0 while a new vector waits.
        out_ready = 1'b0;
        send_vec(V255, lat);
        n_cmp++;
        if (lat !== 8) begin
            n_bad++;
            $display("FAIL stall_latency: got %0d required 8", lat);
        end
        @(negedge clk);
        x_in = V128;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (ov_d !== 1'b1 || rdy_d !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hs_c%0d: out_valid=%b in_ready=%b required 1/0", c, ov_d, rdy_d);
            end
            n_cmp++;
            if (int'(yd[0]) !== 721) begin
                n_bad++;
                $display("FAIL stall_y0_c%0d: got %0d required 721", c, yd[0]);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (ov_d !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_retire: out_valid=%b required 0", ov_d);
        end
        lat = 0;
        while (ov_d !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat !== 8 || int'(yd[0]) !== 362) begin
            n_bad++;
            $display("FAIL swap_result: latency=%0d y0=%0d required 8/362", lat, yd[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_enable();
        int lat;
        out_ready = 1'b1;
        @(negedge clk);
        x_in = VALT;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (ov_d !== 1'b1 && lat < 40) begin
            @(negedge clk);
            en = (lat >= 2 && lat < 5) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        en = 1'b1;
        n_cmp++;
        if (lat !== 11) begin
            n_bad++;
            $display("FAIL enable_latency: got %0d edges required 11", lat);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (int'(yd[k]) !== E_ALT[k]) begin
                n_bad++;
                $display("FAIL enable_y%0d: got %0d required %0d", k, yd[k], E_ALT[k]);
            end
        end
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ov_d !== 1'b1 || int'(yd[7]) !== 327) begin
            n_bad++;
            $display("FAIL enable_freeze_out: out_valid=%b y7=%0d required 1/327", ov_d, yd[7]);
        end
        en = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (ov_d !== 1'b0) begin
            n_bad++;
            $display("FAIL enable_resume_retire: out_valid=%b required 0", ov_d);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        out_ready = 1'b1;
        @(negedge clk);
        x_in = V255;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (int'(yd[k]) !== 0) begin
                n_bad++;
                $display("FAIL midrst_y%0d: got %0d required 0", k, yd[k]);
            end
        end
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ov_d !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0 || rdy_d !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_abandon: saw_valid=%b in_ready=%b required 0/1", seen, rdy_d);
        end
        send_vec(V128, lat);
        n_cmp++;
        if (lat !== 8) begin
            n_bad++;
            $display("FAIL midrst_next_latency: got %0d required 8", lat);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (int'(yd[k]) !== E128[k]) begin
                n_bad++;
                $display("FAIL midrst_next_y%0d: got %0d required %0d", k, yd[k], E128[k]);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            V128[i]  = 8'd128;
            V255[i]  = 8'd255;
            VALT[i]  = (i % 2 == 0) ? 8'd255 : 8'd0;
            VZERO[i] = 8'd0;
            E128[i] = 0; E255[i] = 0; E255_LS[i] = 0; E255_SAT[i] = 0; EZ[i] = 0;
        end
        E128[0]     = 362;
        E255[0]     = 721;
        E255_LS[0]  = 359;
        E255_SAT[0] = 511;
        E_ALT = '{361, 65, 0, 77, 0, 115, 0, 327};

        test_reset();
        test_default();
        test_full_scale();
        test_alternating();
        test_back_to_back();
        test_enable();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
